// File: rtl/clock_divider_pkg.sv
// Shared defaults and counter sizing for the game-tick clock divider.
// Pure declarations: no logic, no latency, no flow control.
package clock_divider_pkg;

  localparam int CLK_FREQ_HZ_DEFAULT = 100000000;
  localparam int TICK_HZ_DEFAULT     = 5;

  // Bits needed to hold 0..divisor-1; a degenerate divisor still gets one bit.
  function automatic int cnt_width(input int divisor);
    return (divisor < 2) ? 1 : $clog2(divisor);
  endfunction

endpackage

// File: rtl/modn_counter.sv
// Free-running modulo-N counter; at_max decodes count == N-1 with zero latency.
// No backpressure: advances on every clock out of reset, async active-low clear.
module modn_counter
  import clock_divider_pkg::*;
#(
  parameter int N = 4,
  parameter int W = cnt_width(N)
) (
  input  logic         clk,
  input  logic         reset,
  output logic [W-1:0] count,
  output logic         at_max
);

  localparam logic [W-1:0] MAX = W'(N - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (count == MAX) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign at_max = (count == MAX);

endmodule

// File: rtl/clock_divider.sv
// Derives a one-cycle game_tick every CLK_FREQ_HZ/TICK_HZ cycles; tick is a same-cycle decode of counter.
// No backpressure; CLOCK_DIVIDER_TICK_COUNT_EN adds a 16-bit wrapping tick_count debug output.
module clock_divider
  import clock_divider_pkg::*;
#(
  parameter int CLK_FREQ_HZ = CLK_FREQ_HZ_DEFAULT,
  parameter int TICK_HZ     = TICK_HZ_DEFAULT
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  output logic        game_tick
`ifdef CLOCK_DIVIDER_TICK_COUNT_EN
  ,
  output logic [15:0] tick_count
`endif
);

  localparam int DIVISOR = CLK_FREQ_HZ / TICK_HZ;
  localparam int CNT_W   = cnt_width(DIVISOR);

  if (DIVISOR < 2) begin : g_bad_divisor
    $fatal(1, "clock_divider: DIVISOR must be at least 2");
  end

  if ((CLK_FREQ_HZ % TICK_HZ) != 0) begin : g_trunc_divisor
    $warning("clock_divider: TICK_HZ does not divide CLK_FREQ_HZ, divisor truncated");
  end

  // Named so benches can probe the live count hierarchically.
  logic [CNT_W-1:0] counter;
  logic             at_max;

  modn_counter #(
    .N (DIVISOR),
    .W (CNT_W)
  ) u_modn_counter (
    .clk    (clk_100MHz),
    .reset  (reset),
    .count  (counter),
    .at_max (at_max)
  );

  assign game_tick = at_max;

`ifdef CLOCK_DIVIDER_TICK_COUNT_EN
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      tick_count <= '0;
    end else if (game_tick) begin
      tick_count <= tick_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_clock_divider.sv
// Bench for clock_divider: two small-divisor instances checked every cycle against an edge-count model.
module tb_clock_divider;

  localparam int D_A = 4;
  localparam int D_B = 10;

  logic clk_100MHz = 1'b0;
  logic reset      = 1'b0;
  logic tick_a;
  logic tick_b;
`ifdef CLOCK_DIVIDER_TICK_COUNT_EN
  logic [15:0] tc_a;
  logic [15:0] tc_b;
`endif

  int checks   = 0;
  int failures = 0;

  // Rising edges seen since the last reset release.
  int unsigned k = 0;

  always #5 clk_100MHz = ~clk_100MHz;

  clock_divider #(.CLK_FREQ_HZ(100000000), .TICK_HZ(25000000)) dut_a (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .game_tick  (tick_a)
`ifdef CLOCK_DIVIDER_TICK_COUNT_EN
    ,
    .tick_count (tc_a)
`endif
  );

  clock_divider #(.CLK_FREQ_HZ(100000000), .TICK_HZ(10000000)) dut_b (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .game_tick  (tick_b)
`ifdef CLOCK_DIVIDER_TICK_COUNT_EN
    ,
    .tick_count (tc_b)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk_100MHz or negedge reset) begin
    if (!reset) k <= 0;
    else        k <= k + 1;
  end

  // Every-cycle compare: counter is k mod D, tick exactly on D-1, tick_count is completed periods.
  always @(negedge clk_100MHz) begin
    check("model_cnt_a",  32'(dut_a.counter), k % D_A);
    check("model_tick_a", 32'(tick_a), 32'((k % D_A) == D_A - 1));
    check("model_cnt_b",  32'(dut_b.counter), k % D_B);
    check("model_tick_b", 32'(tick_b), 32'((k % D_B) == D_B - 1));
`ifdef CLOCK_DIVIDER_TICK_COUNT_EN
    check("model_tc_a", 32'(tc_a), (k / D_A) % 65536);
    check("model_tc_b", 32'(tc_b), (k / D_B) % 65536);
`endif
  end

  initial begin
    int n;

    // Held in reset for two cycles.
    repeat (2) @(negedge clk_100MHz);
    check("rst_cnt_a",  32'(dut_a.counter), 0);
    check("rst_tick_a", 32'(tick_a), 0);

    // Release mid-low-phase; first edges read 1 then 2, first tick on the third.
    #2 reset = 1'b1;
    @(posedge clk_100MHz); #1;
    check("rel_cnt_1",  32'(dut_a.counter), 1);
    check("rel_tick_1", 32'(tick_a), 0);
    @(posedge clk_100MHz); #1;
    check("rel_cnt_2",  32'(dut_a.counter), 2);
    check("rel_tick_2", 32'(tick_a), 0);
    @(posedge clk_100MHz); #1;
    check("first_tick_cnt", 32'(dut_a.counter), 3);
    check("first_tick",     32'(tick_a), 1);
    @(posedge clk_100MHz); #1;
    check("wrap_cnt_0",  32'(dut_a.counter), 0);
    check("wrap_tick_0", 32'(tick_a), 0);
    @(posedge clk_100MHz); #1;
    check("wrap_cnt_1", 32'(dut_a.counter), 1);

    // Five edges so far; four more put the divide-by-10 instance on its tick.
    repeat (4) @(posedge clk_100MHz);
    #1;
    check("b_max_cnt", 32'(dut_b.counter), 9);
    check("b_tick",    32'(tick_b), 1);
    @(posedge clk_100MHz); #1;
    check("b_wrap_cnt",  32'(dut_b.counter), 0);
    check("b_wrap_tick", 32'(tick_b), 0);

    // Forty edges since release.
    repeat (30) @(posedge clk_100MHz);
    #1;
`ifdef CLOCK_DIVIDER_TICK_COUNT_EN
    check("tc_after_40", 32'(tc_a), 10);
`endif
    check("cnt_after_40", 32'(dut_b.counter), 0);

    // Asynchronous reset between edges, from counter = 2.
    repeat (2) @(posedge clk_100MHz);
    #3 reset = 1'b0;
    #1;
    check("async_cnt_a", 32'(dut_a.counter), 0);
    check("async_cnt_b", 32'(dut_b.counter), 0);
    check("async_tick",  32'(tick_a), 0);
    repeat (2) @(negedge clk_100MHz);
    #1 reset = 1'b1;

    // Reset asserted during the tick cycle itself.
    n = 0;
    while (tick_a !== 1'b1 && n < 20) begin
      @(negedge clk_100MHz);
      n++;
    end
    check("tick_seen_before_reset", 32'(tick_a), 1);
    #1 reset = 1'b0;
    #1;
    check("midtick_tick_drop", 32'(tick_a), 0);
    check("midtick_cnt_clear", 32'(dut_a.counter), 0);
    @(negedge clk_100MHz);
    #1 reset = 1'b1;

    n = 21;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk_100MHz); #1;
      if (tick_a === 1'b1) begin
        n = i;
        break;
      end
    end
    check("midtick_next_tick_edges", n, 3);

    // Let the every-cycle compare run across several more periods.
    repeat (50) @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_divider.md
Name: clock_divider

Overview:
- Free-running modulo-N counter that derives a periodic single-cycle game tick from the 100 MHz system clock.
- Default: one tick every 20,000,000 cycles (5 Hz).
- Sits at the top of the game datapath. All game-state logic advances on game_tick as a synchronous enable, not as a clock.

Parameters:
- CLK_FREQ_HZ, 100000000, input clock frequency in Hz.
- TICK_HZ, 5, desired game tick rate in Hz.
- DIVISOR (localparam), CLK_FREQ_HZ/TICK_HZ = 20000000, cycles per tick period.
- CNT_W (localparam), $clog2(DIVISOR) = 25, counter width.

Ports:
- clk_100MHz  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- game_tick  output  1  one-cycle-high pulse, once per DIVISOR cycles.

Behaviour:
- Internal register `counter` is CNT_W bits wide, unsigned, and must be named exactly `counter` so benches can probe it hierarchically.
- While reset = 0: counter = 0 and game_tick = 0, immediately and asynchronously, without waiting for a clock edge.
- Reset release is synchronous in effect. The first rising edge with reset = 1 moves counter from 0 to 1.
- Each rising edge with reset = 1:
  - if counter == DIVISOR-1, counter <= 0;
  - otherwise counter <= counter + 1.
- game_tick = (counter == DIVISOR-1), a combinational decode of the registered counter.
  - game_tick is high for exactly the one cycle in which counter holds DIVISOR-1, and low for every other value.
  - No added latency: game_tick and counter == DIVISOR-1 are true together at every sampling edge.
- Period is exactly DIVISOR cycles. After reset release, the first game_tick occurs while counter = DIVISOR-1, i.e. DIVISOR-1 edges after release.
- Wrap: DIVISOR-1 -> 0 -> 1. No value ≥ DIVISOR is ever reachable.
- Reset asserted mid-count, including during the game_tick cycle: counter and game_tick clear immediately, and counting restarts from 0 after release.
- Elaboration check: DIVISOR ≥ 2, otherwise $fatal. TICK_HZ must divide CLK_FREQ_HZ, otherwise $warning (truncated divisor).
- Output glitch-freedom is not required. Consumers sample game_tick synchronously in the clk_100MHz domain.

Optional Feature:
- Macro: CLOCK_DIVIDER_TICK_COUNT_EN.
- Defined:
  - adds output port tick_count, input-side none, 16 bits;
  - tick_count resets to 0 (asynchronously, with reset = 0);
  - increments by 1 on each rising edge where game_tick = 1, wrapping 65535 -> 0;
  - intended for debug and score timing.
- Undefined: port and register are absent. Core behaviour is identical in both cases.

Decomposition:
- Package clock_divider_pkg holds:
  - CLK_FREQ_HZ_DEFAULT = 100000000;
  - TICK_HZ_DEFAULT = 5;
  - a function computing the counter width from a divisor.
- Sub-module modn_counter (parameter N; ports clk, reset, count, at_max) implements the wrap counter.
- clock_divider instantiates modn_counter, drives game_tick from at_max, and exposes `counter` as the instance count signal.

Test Plan:
- Reset check: hold reset = 0 for 2 cycles -> counter = 0, game_tick = 0 at every edge; apply reset = 0 between edges -> both clear without a clock edge.
- Release and increment: release reset -> counter reads 1 after the first edge and 2 after the second; game_tick = 0 throughout.
- Tick timing with default parameters over 1 s of simulated time:
  - game_tick = 1 exactly when counter == 19999999 and 0 otherwise;
  - counter == 19999999 is followed by 0, then 1;
  - 5 ticks counted, spaced 200 ms (20,000,000 cycles) apart.
- Small divisor (TICK_HZ = 25000000, DIVISOR = 4):
  - counter sequence 0,1,2,3,0,1,...;
  - game_tick pattern 0,0,0,1 repeating;
  - first tick 3 edges after release.
- Mid-tick reset with DIVISOR = 4: assert reset while counter = 3 -> game_tick drops immediately; after release the next tick arrives 3 edges later.
- With CLOCK_DIVIDER_TICK_COUNT_EN and DIVISOR = 4:
  - tick_count reads 10 after 40 cycles;
  - forced to 65535, it wraps to 0 on the next tick.
